bcp_scheduler: RTL and testbench
================================

Name: bcp_scheduler

Overview:
Sequences the shared 4-literal unit-clause checker across a clause-status table for one BCP pass.
- Per clause: presents the falsified-literal mask to the checker and samples its unit result.
- Raises an implication handshake for each unit clause.
- Aborts the pass on the first all-false clause (conflict).
- Sits between the solver's assignment/trail logic, which writes masks and consumes implications, and the checker datapath.

Parameters:
NUM_CLAUSES, 16, clause table depth (>=2)
IDX_W, $clog2(NUM_CLAUSES), clause index width

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
START  in  1  begin pass; honoured only when BUSY=0
BUSY  out  1  pass in progress
DONE  out  1  one-cycle pulse: pass finished without conflict
CONFLICT  out  1  level: last pass hit an all-false clause
CONFLICT_IDX  out  IDX_W  index of conflicting clause
IMP_VALID  out  1  implication available
IMP_READY  in  1  consumer accepts implication
IMP_CLAUSE  out  IDX_W  clause index of implication
IMP_LIT  out  2  literal position (0..3) to force true
IMP_COUNT  out  IDX_W+1  implications accepted in current/last pass
CL_WE  in  1  clause mask write strobe
CL_ADDR  in  IDX_W  clause write index
CL_MASK  in  4  mask; bit i=1 means literal i currently false
CHK_ASSIGN  out  4  mask driven to checker
CHK_UNIT  in  4  checker result, same-cycle combinational

Behaviour:
- Reset (async, RST_N=0): state IDLE; all mask entries 4'b0000; BUSY, DONE, CONFLICT, IMP_VALID = 0; CONFLICT_IDX, IMP_CLAUSE, IMP_LIT, IMP_COUNT = 0; CHK_ASSIGN = 0; scan index = 0. Reset mid-pass discards the pass with no DONE.
- States:
  - IDLE: CHK_ASSIGN=0. START -> SCAN with idx=0, IMP_COUNT cleared, CONFLICT cleared.
  - SCAN: BUSY=1, CHK_ASSIGN=mask[idx], one clause per cycle.
    - mask==4'b1111 -> CONFL.
    - Else CHK_UNIT one-hot -> IMPLY. Latch IMP_CLAUSE=idx and IMP_LIT=bit position; IMP_VALID=1 from the next cycle.
    - Else, non-one-hot or zero treated as "no unit": idx==NUM_CLAUSES-1 -> DONE_S, otherwise idx+1.
  - IMPLY: BUSY=1, IMP_VALID held with stable IMP_CLAUSE/IMP_LIT until IMP_READY=1. On handshake cycle: IMP_COUNT+1, IMP_VALID deasserts next cycle, then idx+1 back to SCAN, or DONE_S if idx was last.
  - CONFL: one cycle. CONFLICT=1 and CONFLICT_IDX=idx registered; -> IDLE. CONFLICT holds until next accepted START or reset.
  - DONE_S: DONE=1 for exactly one cycle, BUSY=0; -> IDLE. START in DONE_S is honoured: next state SCAN.
- Latency: no-unit pass takes NUM_CLAUSES SCAN cycles plus 1 DONE cycle. Each implication adds 1 cycle plus IMP_READY wait.
- Writes:
  - CL_WE honoured only when BUSY=0; ignored while BUSY=1.
  - Write and START in the same cycle: write commits, and the scan sees the new value (SCAN starts next cycle).
- START while BUSY=1: ignored.
- IMP_COUNT saturates at 2^(IDX_W+1)-1; unreachable for legal NUM_CLAUSES, but required.

Optional Feature:
BCP_SAT_SKIP_EN
- Defined:
  - Per-clause satisfied bit. Set when that clause's implication handshakes; cleared when the clause is written or on reset.
  - In SCAN, a clause with sat=1 drives CHK_ASSIGN=4'b0000 and advances with no implication or conflict check (still one cycle).
- Undefined: no satisfied array; every clause is evaluated every pass.

Test Plan:
- Reset then START with all masks 0 (NUM_CLAUSES=16) -> BUSY=1 for 16 cycles, DONE pulse on cycle 17, IMP_VALID never 1, IMP_COUNT=0, CONFLICT=0.
- mask[3]=4'b0111, mask[9]=4'b1110, IMP_READY=1 -> two implications (clause 3 lit 3, clause 9 lit 0) in order, IMP_COUNT=2, DONE once.
- mask[5]=4'b1011, IMP_READY low 4 cycles -> IMP_VALID, IMP_CLAUSE=5, IMP_LIT=2 stable all 4 cycles, single count on acceptance.
- mask[2]=4'b1101, mask[7]=4'b1111 -> implication clause 2 lit 1, then CONFLICT=1, CONFLICT_IDX=7, no DONE, clauses 8..15 never driven on CHK_ASSIGN.
- CL_WE to clause 4 during BUSY, START during BUSY, RST_N low mid-IMPLY -> write and START ignored; after reset all outputs 0 and masks cleared.
- BCP_SAT_SKIP_EN: pass with mask[1]=4'b0111 accepted, second START without rewrite -> second pass produces no implication; rewrite clause 1 with the same mask -> implication returns.

Source files
------------

// File: rtl/bcp_scheduler_if.sv
// -----------------------------------------------------------------------------
// bcp_scheduler_if
// Bundles every non-clock signal of the BCP scheduler.
//   master : solver side (start, clause-mask writes, implication consumer)
//            together with the checker datapath (chk_unit)
//   slave  : the scheduler itself
// Signals
//   start        begin pass (honoured only while busy=0)
//   busy         pass in progress
//   done         one-cycle pulse, pass finished without conflict
//   conflict     level, last pass hit an all-false clause
//   conflict_idx index of the conflicting clause
//   imp_valid / imp_ready / imp_clause / imp_lit   implication handshake
//   imp_count    implications accepted in current/last pass
//   cl_we / cl_addr / cl_mask   clause mask write port (bit i=1: literal i false)
//   chk_assign   mask presented to the 4-literal checker
//   chk_unit     checker result, combinational from chk_assign
// -----------------------------------------------------------------------------
interface bcp_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             busy;
    logic             done;
    logic             conflict;
    logic [IDX_W-1:0] conflict_idx;
    logic             imp_valid;
    logic             imp_ready;
    logic [IDX_W-1:0] imp_clause;
    logic [1:0]       imp_lit;
    logic [IDX_W:0]   imp_count;
    logic             cl_we;
    logic [IDX_W-1:0] cl_addr;
    logic [3:0]       cl_mask;
    logic [3:0]       chk_assign;
    logic [3:0]       chk_unit;

    modport master (
        output start, imp_ready, cl_we, cl_addr, cl_mask, chk_unit,
        input  busy, done, conflict, conflict_idx, imp_valid, imp_clause,
               imp_lit, imp_count, chk_assign
    );

    modport slave (
        input  start, imp_ready, cl_we, cl_addr, cl_mask, chk_unit,
        output busy, done, conflict, conflict_idx, imp_valid, imp_clause,
               imp_lit, imp_count, chk_assign
    );
endinterface

// File: rtl/bcp_scheduler.sv
// -----------------------------------------------------------------------------
// bcp_scheduler
// Walks the clause-status table once per BCP pass, presenting each clause's
// falsified-literal mask to the shared 4-literal unit checker. A unit clause
// raises an implication handshake; an all-false clause aborts the pass with a
// conflict; a clean pass ends with a one-cycle done pulse.
// Ports
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    bcp_scheduler_if.slave (see the interface file for signal list)
// Parameters
//   NUM_CLAUSES  clause table depth (>=2)
//   IDX_W        clause index width
// Optional feature
//   BCP_SAT_SKIP_EN  when defined, a clause whose implication was accepted is
//                    marked satisfied and skipped (chk_assign=0, no checks)
//                    until it is rewritten or reset.
// -----------------------------------------------------------------------------
module bcp_scheduler #(
    parameter int NUM_CLAUSES = 16,
    parameter int IDX_W       = $clog2(NUM_CLAUSES)
) (
    input  logic           clk,
    input  logic           rst_n,
    bcp_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        IMPLY,
        CONFL,
        DONE_S
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       mask_q [NUM_CLAUSES];
    logic [IDX_W-1:0] imp_clause_q;
    logic [1:0]       imp_lit_q;
    logic [IDX_W:0]   imp_count_q;
    logic             conflict_q;
    logic [IDX_W-1:0] conflict_idx_q;

`ifdef BCP_SAT_SKIP_EN
    logic [NUM_CLAUSES-1:0] sat_q;
`endif

    // Decode of the clause currently under the scan pointer.
    logic [3:0] cur_mask;
    logic       cur_skip;
    logic       cur_conflict;
    logic       cur_unit;
    logic [1:0] cur_lit;

    logic busy;
    logic wr_accept;

    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cur_mask = mask_q[idx_q];
        cur_skip = 1'b0;
`ifdef BCP_SAT_SKIP_EN
        cur_skip = sat_q[idx_q];
`endif
        cur_conflict = !cur_skip && (cur_mask == 4'b1111);
        // Only a strictly one-hot checker result counts as a unit clause;
        // zero or multi-hot results are treated as "no unit".
        cur_unit = !cur_skip && !cur_conflict && (bus.chk_unit != 4'b0000)
                   && ((bus.chk_unit & (bus.chk_unit - 4'd1)) == 4'b0000);
        cur_lit = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.chk_unit[i]) cur_lit = 2'(i);
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = SCAN;
            end
            SCAN: begin
                if (cur_conflict)            state_d = CONFL;
                else if (cur_unit)           state_d = IMPLY;
                else if (idx_q == LAST_IDX)  state_d = DONE_S;
            end
            IMPLY: begin
                if (bus.imp_ready) state_d = (idx_q == LAST_IDX) ? DONE_S : SCAN;
            end
            CONFL:   state_d = IDLE;
            // A start landing on the done cycle chains straight into a new pass.
            DONE_S:  state_d = bus.start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy           = 1'b0;
        bus.done       = 1'b0;
        bus.imp_valid  = 1'b0;
        bus.chk_assign = 4'b0000;
        unique case (state_q)
            SCAN: begin
                busy           = 1'b1;
                bus.chk_assign = cur_skip ? 4'b0000 : cur_mask;
            end
            IMPLY: begin
                busy          = 1'b1;
                bus.imp_valid = 1'b1;
            end
            CONFL:   busy     = 1'b1;
            DONE_S:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy         = busy;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_idx = conflict_idx_q;
    assign bus.imp_clause   = imp_clause_q;
    assign bus.imp_lit      = imp_lit_q;
    assign bus.imp_count    = imp_count_q;

    // Table writes are only accepted between passes so a scan never sees a
    // mask change underneath it.
    assign wr_accept = bus.cl_we && !busy;

    // Scan pointer, implication latch, counters and conflict record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            imp_clause_q   <= '0;
            imp_lit_q      <= '0;
            imp_count_q    <= '0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE_S: begin
                    if (bus.start) begin
                        idx_q       <= '0;
                        imp_count_q <= '0;
                        conflict_q  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (cur_conflict) begin
                        conflict_q     <= 1'b1;
                        conflict_idx_q <= idx_q;
                    end else if (cur_unit) begin
                        imp_clause_q <= idx_q;
                        imp_lit_q    <= cur_lit;
                    end else if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                IMPLY: begin
                    if (bus.imp_ready) begin
                        if (imp_count_q != '1) imp_count_q <= imp_count_q + 1'b1;
                        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clause mask table.
    // NOTE: the table is reset explicitly because a freshly reset solver must
    // scan an all-clear table; this costs a reset on every entry instead of a
    // plain RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLAUSES; i++) mask_q[i] <= 4'b0000;
        end else if (wr_accept) begin
            mask_q[bus.cl_addr] <= bus.cl_mask;
        end
    end

`ifdef BCP_SAT_SKIP_EN
    // Satisfied flags: set when a clause's implication is accepted, cleared
    // whenever the clause is rewritten. Writes and handshakes never coincide
    // because writes need busy=0 and handshakes happen only while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else begin
            if (state_q == IMPLY && bus.imp_ready) sat_q[imp_clause_q] <= 1'b1;
            if (wr_accept)                          sat_q[bus.cl_addr]  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bcp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bcp_scheduler
// Self-checking bench for bcp_scheduler. A behavioural model walks the clause
// table as a plain array and predicts, per pass, the masks shown to the checker,
// the implication sequence, conflict outcome, implication count and cycle
// count. The 4-literal checker is modelled combinationally. Build with
// +define+BCP_SAT_SKIP_EN to exercise the satisfied-skip feature.
// -----------------------------------------------------------------------------
module tb_bcp_scheduler;

    localparam int N      = 16;
    localparam int IDX_W  = $clog2(N);
    localparam int BUDGET = 300;

`ifdef BCP_SAT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [IDX_W-1:0] clause;
        logic [1:0]       lit;
    } imp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] model_mask [N];
    bit         model_sat  [N];

    bcp_scheduler_if #(.IDX_W(IDX_W)) bus ();

    bcp_scheduler #(
        .NUM_CLAUSES (N),
        .IDX_W       (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Checker: a clause is unit when exactly three literals are false; the
    // result is one-hot on the remaining literal.
    always_comb begin
        bus.chk_unit = ($countones(bus.chk_assign) == 3) ? ~bus.chk_assign : 4'b0000;
    end

    function automatic logic [3:0] rand_mask();
        int r;
        logic [3:0] m;
        r = $urandom_range(0, 99);
        if (r < 4) return 4'b1111;
        if (r < 40) begin
            m = 4'b1111;
            m[$urandom_range(0, 3)] = 1'b0;
            return m;
        end
        m = 4'($urandom_range(0, 15));
        if ($countones(m) >= 3) m = 4'b0000;
        return m;
    endfunction

    task automatic write_clause(input int a, input logic [3:0] m);
        @(negedge clk);
        bus.cl_we   = 1'b1;
        bus.cl_addr = IDX_W'(a);
        bus.cl_mask = m;
        @(negedge clk);
        bus.cl_we   = 1'b0;
        model_mask[a] = m;
        model_sat[a]  = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks every output is zero, releases it.
    task automatic test_reset(input string tag);
        logic [31:0] got [9];
        string       nm  [9];
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.cl_we     = 1'b0;
        bus.imp_ready = 1'b0;
        #3;
        got[0] = 32'(bus.busy);         nm[0] = "busy";
        got[1] = 32'(bus.done);         nm[1] = "done";
        got[2] = 32'(bus.conflict);     nm[2] = "conflict";
        got[3] = 32'(bus.imp_valid);    nm[3] = "imp_valid";
        got[4] = 32'(bus.conflict_idx); nm[4] = "conflict_idx";
        got[5] = 32'(bus.imp_clause);   nm[5] = "imp_clause";
        got[6] = 32'(bus.imp_lit);      nm[6] = "imp_lit";
        got[7] = 32'(bus.imp_count);    nm[7] = "imp_count";
        got[8] = 32'(bus.chk_assign);   nm[8] = "chk_assign";
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (got[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL %s %s: got %0h, expected 0", tag, nm[i], got[i]);
            end
        end
        for (int c = 0; c < N; c++) begin
            model_mask[c] = 4'b0000;
            model_sat[c]  = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one pass and checks it against the model.
    //   fixed_wait <0 : random IMP_READY delay 0..3 per implication
    //   wr_start      : clause write (wa, wm) in the same cycle as START
    //   inject        : pulse START and a write of 4'b1111 to clause 4 while
    //                   the first implication is pending (both must be ignored)
    task automatic run_pass(input string tag, input int fixed_wait, input bit wr_start,
                            input logic [IDX_W-1:0] wa, input logic [3:0] wm,
                            input bit inject);
        logic [3:0]       exp_scan [$];
        logic [3:0]       obs_scan [$];
        imp_t             exp_imp  [$];
        imp_t             acc      [$];
        imp_t             cur;
        imp_t             tmp;
        bit               exp_conf;
        logic [IDX_W-1:0] exp_cidx;
        int               n_exp, exp_cycles, cycles, waited, want;
        bit               in_imp, have_exp, injected, dirty, scan_ok;

        exp_conf = 1'b0; exp_cidx = '0; cycles = 0; waited = 0; want = 0;
        in_imp = 1'b0; have_exp = 1'b0; injected = 1'b0; dirty = 1'b0;

        @(negedge clk);
        bus.start = 1'b1;
        if (wr_start) begin
            bus.cl_we     = 1'b1;
            bus.cl_addr   = wa;
            bus.cl_mask   = wm;
            model_mask[wa] = wm;
            model_sat[wa]  = 1'b0;
        end

        for (int c = 0; c < N; c++) begin
            if (SKIP && model_sat[c]) begin
                exp_scan.push_back(4'b0000);
                continue;
            end
            exp_scan.push_back(model_mask[c]);
            if (model_mask[c] == 4'b1111) begin
                exp_conf = 1'b1;
                exp_cidx = IDX_W'(c);
                break;
            end
            if ($countones(model_mask[c]) == 3) begin
                for (int b = 0; b < 4; b++) begin
                    if (!model_mask[c][b]) begin
                        tmp.clause = IDX_W'(c);
                        tmp.lit    = 2'(b);
                        exp_imp.push_back(tmp);
                    end
                end
            end
        end
        n_exp      = exp_imp.size();
        exp_cycles = exp_scan.size() + (exp_conf ? 1 : 0);

        @(negedge clk);
        bus.start = 1'b0;
        bus.cl_we = 1'b0;

        while (bus.busy === 1'b1 && cycles < BUDGET) begin
            if (dirty) begin
                bus.start   = 1'b0;
                bus.cl_we   = 1'b0;
                bus.cl_addr = '0;
                bus.cl_mask = 4'b0000;
                dirty       = 1'b0;
            end
            if (bus.imp_valid === 1'b1) begin
                if (!in_imp) begin
                    in_imp = 1'b1;
                    waited = 0;
                    want   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                    exp_cycles += want + 1;
                    have_exp = (exp_imp.size() > 0);
                    if (have_exp) begin
                        cur = exp_imp.pop_front();
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s unexpected implication: got clause %0d lit %0d, expected none",
                                 tag, bus.imp_clause, bus.imp_lit);
                    end
                    if (inject && !injected) begin
                        bus.start   = 1'b1;
                        bus.cl_we   = 1'b1;
                        bus.cl_addr = IDX_W'(4);
                        bus.cl_mask = 4'b1111;
                        injected    = 1'b1;
                        dirty       = 1'b1;
                    end
                end
                if (have_exp) begin
                    n_cmp++;
                    if (bus.imp_clause !== cur.clause || bus.imp_lit !== cur.lit) begin
                        n_bad++;
                        $display("FAIL %s imp fields (wait cycle %0d): got clause %0d lit %0d, expected clause %0d lit %0d",
                                 tag, waited, bus.imp_clause, bus.imp_lit, cur.clause, cur.lit);
                    end
                end
                if (waited == want) begin
                    bus.imp_ready = 1'b1;
                    if (have_exp) acc.push_back(cur);
                    in_imp = 1'b0;
                end else begin
                    bus.imp_ready = 1'b0;
                    waited++;
                end
            end else begin
                bus.imp_ready = 1'b0;
                if (bus.conflict !== 1'b1) obs_scan.push_back(bus.chk_assign);
            end
            cycles++;
            @(negedge clk);
        end

        bus.imp_ready = 1'b0;
        bus.start     = 1'b0;
        bus.cl_we     = 1'b0;
        bus.cl_addr   = '0;
        bus.cl_mask   = 4'b0000;

        n_cmp++;
        if (cycles >= BUDGET) begin
            n_bad++;
            $display("FAIL %s timeout: busy still %b after %0d cycles", tag, bus.busy, cycles);
        end
        n_cmp++;
        if (bus.done !== !exp_conf) begin
            n_bad++;
            $display("FAIL %s done at pass end: got %b, expected %b", tag, bus.done, !exp_conf);
        end
        n_cmp++;
        if (bus.conflict !== exp_conf) begin
            n_bad++;
            $display("FAIL %s conflict: got %b, expected %b", tag, bus.conflict, exp_conf);
        end
        if (exp_conf) begin
            n_cmp++;
            if (bus.conflict_idx !== exp_cidx) begin
                n_bad++;
                $display("FAIL %s conflict_idx: got %0d, expected %0d", tag, bus.conflict_idx, exp_cidx);
            end
        end
        n_cmp++;
        if (bus.imp_count !== (IDX_W+1)'(n_exp)) begin
            n_bad++;
            $display("FAIL %s imp_count: got %0d, expected %0d", tag, bus.imp_count, n_exp);
        end
        n_cmp++;
        if (exp_imp.size() != 0) begin
            n_bad++;
            $display("FAIL %s missing implications: got %0d, expected %0d",
                     tag, n_exp - exp_imp.size(), n_exp);
        end
        n_cmp++;
        if (cycles != exp_cycles) begin
            n_bad++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", tag, cycles, exp_cycles);
        end
        scan_ok = (obs_scan.size() == exp_scan.size());
        if (scan_ok) begin
            foreach (exp_scan[i]) if (obs_scan[i] !== exp_scan[i]) scan_ok = 1'b0;
        end
        n_cmp++;
        if (!scan_ok) begin
            n_bad++;
            $display("FAIL %s chk_assign sequence: got %0d entries, expected %0d (%p vs %p)",
                     tag, obs_scan.size(), exp_scan.size(), obs_scan, exp_scan);
        end

        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after pass: got done=%b busy=%b, expected 0/0", tag, bus.done, bus.busy);
        end

        if (SKIP) foreach (acc[i]) model_sat[acc[i].clause] = 1'b1;
    endtask

    task automatic test_all_zero();
        run_pass("all_zero", 0, 1'b0, '0, 4'b0000, 1'b0);
    endtask

    task automatic test_two_imps();
        write_clause(3, 4'b0111);
        write_clause(9, 4'b1110);
        run_pass("two_imps", 0, 1'b0, '0, 4'b0000, 1'b0);
    endtask

    task automatic test_ready_stall();
        write_clause(3, 4'b0000);
        write_clause(9, 4'b0000);
        write_clause(5, 4'b1011);
        run_pass("ready_stall", 4, 1'b0, '0, 4'b0000, 1'b0);
    endtask

    task automatic test_conflict();
        write_clause(5, 4'b0000);
        write_clause(2, 4'b1101);
        write_clause(7, 4'b1111);
        run_pass("conflict", -1, 1'b0, '0, 4'b0000, 1'b0);
        write_clause(2, 4'b0000);
        write_clause(7, 4'b0000);
    endtask

    task automatic test_write_with_start();
        run_pass("write_with_start", -1, 1'b1, IDX_W'(10), 4'b1011, 1'b0);
        write_clause(10, 4'b0000);
    endtask

    task automatic test_busy_ignore();
        write_clause(1, 4'b0111);
        run_pass("busy_ignore", 3, 1'b0, '0, 4'b0000, 1'b1);
        write_clause(1, 4'b0000);
    endtask

    task automatic test_sat_skip();
        write_clause(1, 4'b0111);
        run_pass("sat_first", 0, 1'b0, '0, 4'b0000, 1'b0);
        run_pass("sat_second", 0, 1'b0, '0, 4'b0000, 1'b0);
        write_clause(1, 4'b0111);
        run_pass("sat_rewrite", 0, 1'b0, '0, 4'b0000, 1'b0);
        write_clause(1, 4'b0000);
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 2) == 0) write_clause(c, rand_mask());
            end
            run_pass($sformatf("random_%0d", p), -1, 1'b0, '0, 4'b0000, 1'b0);
        end
    endtask

    task automatic test_reset_mid_imply();
        int n;
        n = 0;
        for (int c = 0; c < N; c++) write_clause(c, 4'b0000);
        write_clause(6, 4'b0111);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.imp_valid !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= BUDGET || bus.imp_clause !== IDX_W'(6)) begin
            n_bad++;
            $display("FAIL mid_imply setup: got imp_valid=%b clause %0d after %0d cycles, expected 1 / 6",
                     bus.imp_valid, bus.imp_clause, n);
        end
        #2;
        test_reset("mid_imply");
        // Table must come back all-clear: a plain clean pass.
        run_pass("after_reset", 0, 1'b0, '0, 4'b0000, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.imp_ready = 1'b0;
        bus.cl_we     = 1'b0;
        bus.cl_addr   = '0;
        bus.cl_mask   = 4'b0000;

        test_reset("power_on");
        test_all_zero();
        test_two_imps();
        test_ready_stall();
        test_conflict();
        test_write_with_start();
        test_busy_ignore();
        test_sat_skip();
        test_random();
        test_reset_mid_imply();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
